counter_step_ctrl: RTL and testbench

Run/pause/step sequencer for the 3-bit count datapath: it owns the 3-bit count register and decides on which clock edges it advances, in which direction, and when it stops. It replaces the free-running flip-flop counter wherever the board needs start/stop/single-step control and a programmable stop value. The current value is shown on the 7-segment display through the shared `display7` decoder.

---
 rtl/counter_step_ctrl_pkg.sv | 29 ++
 rtl/counter_step_ctrl_if.sv | 27 ++
 rtl/counter_step_ctrl_display7.sv | 32 +++
 rtl/counter_step_ctrl.sv | 113 +++++++++++
 tb/tb_counter_step_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/counter_step_ctrl_pkg.sv
// Shared definitions for the run/pause/step count sequencer: state
// encoding, count width, load values and the +/-1 step helper.
package counter_step_ctrl_pkg;

   localparam int CNT_W = 3;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   localparam cnt_t LOAD_UP = 3'd0;
   localparam cnt_t LOAD_DN = 3'd7;

   // Starting value for a fresh load in the given direction.
   function automatic cnt_t load_val(input logic up);
      return up ? LOAD_UP : LOAD_DN;
   endfunction

   // One count step, wrapping modulo 8 in either direction.
   function automatic cnt_t step_cnt(input cnt_t q, input logic up);
      return up ? cnt_t'(q + 3'd1) : cnt_t'(q - 3'd1);
   endfunction

endpackage

// File: rtl/counter_step_ctrl_if.sv
// Control and status bundle of the count sequencer. The board side
// (master) drives the requests; the sequencer (slave) drives the status.
interface counter_step_ctrl_if;
   import counter_step_ctrl_pkg::*;

   logic       iStart;
   logic       iStop;
   logic       iStep;
   logic       iUp;
   cnt_t       iLimit;
   cnt_t       oQ;
   logic [1:0] oState;
   logic       oTick;
   logic       oDone;
   logic [6:0] oDisplay;

   modport master (
      output iStart, iStop, iStep, iUp, iLimit,
      input  oQ, oState, oTick, oDone, oDisplay
   );

   modport slave (
      input  iStart, iStop, iStep, iUp, iLimit,
      output oQ, oState, oTick, oDone, oDisplay
   );

endinterface

// File: rtl/counter_step_ctrl_display7.sv
// Hex digit to 7-segment decoder, segments ordered {g,f,e,d,c,b,a},
// active-high.
module display7 (
   input  logic [3:0] value,
   output logic [6:0] seg
);

   // Pure lookup of the segment pattern for each hex digit.
   always_comb begin
      seg = 7'h00;
      case (value)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = 7'h00;
      endcase
   end

endmodule

// File: rtl/counter_step_ctrl.sv
// Run/pause/step sequencer owning the 3-bit count register. In RUN the
// count advances once every DIV clocks; PAUSE allows single steps; the
// sequencer parks in DONE when an update lands on the programmed limit.
module counter_step_ctrl
   import counter_step_ctrl_pkg::*;
#(
   parameter int DIV = 4
) (
   input logic              CLK,
   input logic              rst_n,
   counter_step_ctrl_if.slave bus
);

   // Prescaler is sized for the largest legal DIV (16 -> values 0..15).
   localparam logic [3:0] PRE_MAX = 4'(DIV - 1);

   state_t     state_q, state_d;
   cnt_t       q_q, q_d;
   logic [3:0] pre_q, pre_d;
   logic       up_q, up_d;
   logic       tick_q, tick_d;
   logic       done_q;
   logic       load;
   logic       upd;

   // Next-state logic: pick load/update/transition with priority stop > start > step.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      pre_d   = pre_q;
      up_d    = up_q;
      tick_d  = 1'b0;
      load    = 1'b0;
      upd     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!bus.iStop && bus.iStart) load = 1'b1;
         end
         ST_RUN: begin
            // A stop on the edge an update is due suppresses that update;
            // the prescaler keeps its phase.
            if (bus.iStop) begin
               state_d = ST_PAUSE;
            end else if (pre_q == PRE_MAX) begin
               pre_d = 4'd0;
               upd   = 1'b1;
            end else begin
               pre_d = pre_q + 4'd1;
            end
         end
         ST_PAUSE: begin
            if (bus.iStop) begin
               state_d = ST_PAUSE;
            end else if (bus.iStart) begin
               state_d = ST_RUN;
               pre_d   = 4'd0;
            end else if (bus.iStep) begin
               upd = 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.iStop) state_d = ST_IDLE;
            else if (bus.iStart) load = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // Load never triggers the limit compare; only updates do.
      if (load) begin
         up_d    = bus.iUp;
         q_d     = load_val(bus.iUp);
         pre_d   = 4'd0;
         state_d = ST_RUN;
      end

      if (upd) begin
         q_d    = step_cnt(q_q, up_q);
         tick_d = 1'b1;
         if (q_d == bus.iLimit) state_d = ST_DONE;
      end
   end

   // State, count, prescaler, direction and status flags.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         q_q     <= LOAD_UP;
         pre_q   <= 4'd0;
         up_q    <= 1'b1;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         pre_q   <= pre_d;
         up_q    <= up_d;
         tick_q  <= tick_d;
         done_q  <= (state_d == ST_DONE);
      end
   end

   assign bus.oQ     = q_q;
   assign bus.oState = state_q;
   assign bus.oTick  = tick_q;
   assign bus.oDone  = done_q;

   display7 u_display7 (
      .value ({1'b0, q_q}),
      .seg   (bus.oDisplay)
   );

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Bench for the run/pause/step count sequencer: directed scenarios then
// random traffic, every cycle compared against a behavioural model.
module tb_counter_step_ctrl;

   localparam int DIV = 4;
   localparam logic [6:0] SEG [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                                      7'h66, 7'h6D, 7'h7D, 7'h07};

   logic CLK = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   // Behavioural model: state as 0..3, count as int mod 8, and the number
   // of RUN edges still to wait before the next update.
   int   mst, mq, mleft;
   bit   mup, mtick;

   bit       cur_up;
   bit [2:0] cur_lim;
   int       ticks;

   counter_step_ctrl_if bus_if ();

   counter_step_ctrl #(.DIV(DIV)) dut (
      .CLK   (CLK),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int got, input int want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic advance(input int lim);
      mq    = (mq + (mup ? 1 : 7)) % 8;
      mtick = 1'b1;
      if (mq == lim) mst = 3;
   endtask

   task automatic load(input bit u);
      mup   = u;
      mq    = u ? 0 : 7;
      mleft = DIV;
      mst   = 1;
   endtask

   task automatic model(input bit r, input bit s, input bit p, input bit stp,
                        input bit u, input int lim);
      mtick = 1'b0;
      if (!r) begin
         mst = 0; mq = 0; mleft = DIV; mup = 1'b1;
      end else begin
         case (mst)
            0: if (!p && s) load(u);
            1: if (p) mst = 2;
               else begin
                  mleft--;
                  if (mleft == 0) begin
                     mleft = DIV;
                     advance(lim);
                  end
               end
            2: if (!p) begin
                  if (s) begin mst = 1; mleft = DIV; end
                  else if (stp) advance(lim);
               end
            3: if (p) mst = 0;
               else if (s) load(u);
            default: mst = 0;
         endcase
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".oQ"},       int'(bus_if.oQ),       mq);
      chk({tag, ".oState"},   int'(bus_if.oState),   mst);
      chk({tag, ".oTick"},    int'(bus_if.oTick),    int'(mtick));
      chk({tag, ".oDone"},    int'(bus_if.oDone),    (mst == 3) ? 1 : 0);
      chk({tag, ".oDisplay"}, int'(bus_if.oDisplay), int'(SEG[mq]));
   endtask

   task automatic edge_in(input bit r, input bit s, input bit p, input bit stp,
                          input string tag);
      rst_n          = r;
      bus_if.iStart  = s;
      bus_if.iStop   = p;
      bus_if.iStep   = stp;
      bus_if.iUp     = cur_up;
      bus_if.iLimit  = cur_lim;
      @(posedge CLK);
      model(r, s, p, stp, cur_up, int'(cur_lim));
      #1;
      check_all(tag);
      if (bus_if.oTick === 1'b1) ticks++;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) edge_in(1'b1, 1'b0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      rst_n = 1'b0;
      bus_if.iStart = 1'b0; bus_if.iStop = 1'b0; bus_if.iStep = 1'b0;
      bus_if.iUp = 1'b1; bus_if.iLimit = 3'd0;
      cur_up = 1'b1; cur_lim = 3'd5;
      mst = 0; mq = 0; mleft = DIV; mup = 1'b1; mtick = 1'b0;

      // Power-on reset
      edge_in(1'b0, 1'b0, 1'b0, 1'b0, "rst0");
      edge_in(1'b0, 1'b0, 1'b0, 1'b0, "rst1");
      chk("rst.oQ", int'(bus_if.oQ), 0);
      chk("rst.oState", int'(bus_if.oState), 0);
      chk("rst.oDisplay", int'(bus_if.oDisplay), 'h3F);

      // Up run to limit 5
      cur_up = 1'b1; cur_lim = 3'd5;
      edge_in(1'b1, 1'b1, 1'b0, 1'b0, "up.start");
      ticks = 0;
      idle(20, "up.run");
      chk("up.q5", int'(bus_if.oQ), 5);
      chk("up.done", int'(bus_if.oDone), 1);
      chk("up.state", int'(bus_if.oState), 3);
      chk("up.ticks", ticks, 5);
      idle(3, "up.hold");
      chk("up.frozen", int'(bus_if.oQ), 5);

      // Down with limit 6, then a full lap back to 7
      cur_up = 1'b0; cur_lim = 3'd6;
      edge_in(1'b1, 1'b1, 1'b0, 1'b0, "dn.start");
      chk("dn.load7", int'(bus_if.oQ), 7);
      idle(4, "dn.run");
      chk("dn.q6", int'(bus_if.oQ), 6);
      chk("dn.done", int'(bus_if.oDone), 1);
      cur_lim = 3'd7;
      edge_in(1'b1, 1'b1, 1'b0, 1'b0, "lap.start");
      ticks = 0;
      idle(8 * DIV, "lap.run");
      chk("lap.q7", int'(bus_if.oQ), 7);
      chk("lap.done", int'(bus_if.oDone), 1);
      chk("lap.ticks", ticks, 8);

      // Stop on a due update, then three single steps to the limit
      cur_up = 1'b1; cur_lim = 3'd7;
      edge_in(1'b1, 1'b1, 1'b0, 1'b0, "ps.start");
      idle(2 * DIV + DIV - 1, "ps.run");
      chk("ps.q2", int'(bus_if.oQ), 2);
      edge_in(1'b1, 1'b0, 1'b1, 1'b0, "ps.stop");
      chk("ps.pause", int'(bus_if.oState), 2);
      chk("ps.held", int'(bus_if.oQ), 2);
      cur_lim = 3'd5;
      for (int k = 0; k < 3; k++) begin
         edge_in(1'b1, 1'b0, 1'b0, 1'b1, "ps.step");
         chk("ps.steptick", int'(bus_if.oTick), 1);
         idle(1, "ps.gap");
      end
      chk("ps.q5", int'(bus_if.oQ), 5);
      chk("ps.done", int'(bus_if.oState), 3);

      // Priority: all requests together in RUN, then in DONE
      edge_in(1'b1, 1'b1, 1'b0, 1'b0, "pr.start");
      idle(2, "pr.run");
      edge_in(1'b1, 1'b1, 1'b1, 1'b1, "pr.all_run");
      chk("pr.pause", int'(bus_if.oState), 2);
      edge_in(1'b1, 1'b1, 1'b0, 1'b0, "pr.resume");
      idle(5 * DIV, "pr.run2");
      chk("pr.done", int'(bus_if.oState), 3);
      edge_in(1'b1, 1'b1, 1'b1, 1'b1, "pr.all_done");
      chk("pr.idle", int'(bus_if.oState), 0);
      chk("pr.keep", int'(bus_if.oQ), 5);

      // Reset mid-RUN
      edge_in(1'b1, 1'b1, 1'b0, 1'b0, "mr.start");
      idle(6, "mr.run");
      edge_in(1'b0, 1'b1, 1'b0, 1'b1, "mr.rst0");
      edge_in(1'b0, 1'b0, 1'b1, 1'b0, "mr.rst1");
      chk("mr.q", int'(bus_if.oQ), 0);
      chk("mr.tick", int'(bus_if.oTick), 0);
      chk("mr.done", int'(bus_if.oDone), 0);

      // Display walk 0..7 by single steps
      cur_up = 1'b1; cur_lim = 3'd0;
      edge_in(1'b1, 1'b1, 1'b0, 1'b0, "ds.start");
      edge_in(1'b1, 1'b0, 1'b1, 1'b0, "ds.stop");
      for (int k = 1; k <= 8; k++) begin
         edge_in(1'b1, 1'b0, 1'b0, 1'b1, "ds.step");
         chk("ds.seg", int'(bus_if.oDisplay), int'(SEG[k % 8]));
      end
      chk("ds.done", int'(bus_if.oState), 3);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) cur_lim = 3'($urandom_range(0, 7));
         cur_up = 1'($urandom_range(0, 1));
         edge_in($urandom_range(0, 99) != 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) == 0,
                 "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
